// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Data-memory side of the pipelined CPU. Serves MEM-stage loads/stores from
//   an on-chip word RAM plus a 4-register MMIO window. Load data is
//   combinational, so the CPU's MEM/WB register captures it at the closing edge.
// Ports:
//   clk_i, rst_i        clock, synchronous active-low reset
//   memAddr_i/memData_i CPU address and store data
//   memRead_i/memWrite_i CPU load/store strobes (one access per cycle)
//   memData_o           combinational load data (0 when idle or faulting)
//   load_en_i/addr/data preload write port (works during reset)
//   busy_o              mirrors load_en_i; CPU stores are dropped while high
//   port_o              MMIO PORT register
//   fault_o/fault_addr_o sticky fault flag and first faulting address
module data_mem_responder #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter int                DEPTH     = 256,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 16'hFF00
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [ADDR_W-1:0]        memAddr_i,
  input  logic [DATA_W-1:0]        memData_i,
  input  logic                     memRead_i,
  input  logic                     memWrite_i,
  output logic [DATA_W-1:0]        memData_o,
  input  logic                     load_en_i,
  input  logic [$clog2(DEPTH)-1:0] load_addr_i,
  input  logic [DATA_W-1:0]        load_data_i,
  output logic                     busy_o,
  output logic [DATA_W-1:0]        port_o,
  output logic                     fault_o,
  output logic [ADDR_W-1:0]        fault_addr_o
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_port, r_cycles, r_wrcnt;
  logic              r_fault;
  logic [ADDR_W-1:0] r_fault_addr;

  logic [ADDR_W-1:0] w_mmio_off;
  logic [1:0]        w_mmio_sel;
  logic              w_ram_hit, w_mmio_hit, w_legal, w_fault;
  logic              w_store, w_st_ram, w_st_mmio;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rdata;

  // Address decode
  assign w_ram_hit  = memAddr_i < ADDR_W'(DEPTH);
  assign w_mmio_off = memAddr_i - MMIO_BASE;
  assign w_mmio_sel = w_mmio_off[1:0];
  assign w_mmio_hit = (memAddr_i >= MMIO_BASE) && (w_mmio_off[ADDR_W-1:2] == '0);
  assign w_legal    = w_ram_hit | w_mmio_hit;
  assign w_idx      = memAddr_i[IDX_W-1:0];

  // Illegal access, or a simultaneous load+store anywhere
  assign w_fault = ((memRead_i | memWrite_i) & ~w_legal) | (memRead_i & memWrite_i);

  // Committed CPU store; ~memRead_i already excludes the load+store fault case
  assign w_store   = rst_i & memWrite_i & ~memRead_i & w_legal & ~load_en_i;
  assign w_st_ram  = w_store & w_ram_hit;
  assign w_st_mmio = w_store & w_mmio_hit;

  // RAM: preload takes the single write port; it also blocks CPU stores, so the
  // two never collide. No reset so contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (load_en_i)     r_mem[load_addr_i] <= load_data_i;
    else if (w_st_ram) r_mem[w_idx]       <= memData_i;
  end

  // MMIO registers and fault tracking
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_port       <= '0;
      r_cycles     <= '0;
      r_wrcnt      <= '0;
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else begin
      // A CYCLES store replaces this cycle's increment
      r_cycles <= (w_st_mmio && w_mmio_sel == 2'd1) ? memData_i : r_cycles + DATA_W'(1);
      if (w_st_mmio && w_mmio_sel == 2'd0) r_port <= memData_i;
      if (w_st_ram && r_wrcnt != '1)       r_wrcnt <= r_wrcnt + DATA_W'(1);
      if (w_fault) begin
        r_fault <= 1'b1;
        if (!r_fault) r_fault_addr <= memAddr_i;
      end else if (w_st_mmio && w_mmio_sel == 2'd3 && memData_i[0]) begin
        r_fault      <= 1'b0;
        r_fault_addr <= '0;
      end
    end
  end

  // Combinational load path
  always_comb begin
    w_rdata = '0;
    if (memRead_i && !w_fault) begin
      if (w_ram_hit) w_rdata = r_mem[w_idx];
      else begin
        case (w_mmio_sel)
          2'd0:    w_rdata = r_port;
          2'd1:    w_rdata = r_cycles;
          2'd2:    w_rdata = r_wrcnt;
          default: w_rdata = {{(DATA_W-1){1'b0}}, r_fault};
        endcase
      end
    end
  end

  assign memData_o    = w_rdata;
  assign busy_o       = load_en_i;
  assign port_o       = r_port;
  assign fault_o      = r_fault;
  assign fault_addr_o = r_fault_addr;
endmodule
